tx_gearbox_66_32: RTL
=====================

// Module: tx_gearbox_66_32
//
// PURPOSE
// - TX gearbox between the 64b/66b encoder and the 32-bit transceiver TX data port.
// - Packs each 66-bit block (2-bit sync header + 64-bit payload) onto a 32-bit/cycle
//   stream, header first on the wire, LSB-first.
// - 16 blocks (1056 bits) fill 33 output words. So the block stalls the upstream
//   stages for 1 cycle in every 33 through o_tx_pause.
//
// PARAMETERS
// - DATA_WIDTH  32  output word width; only 32 is supported (elaboration error otherwise)
// - SEQ_MAX     32  last sequence count; the pause cycle; period = SEQ_MAX+1
//
// PORTS
// - i_txc        in   1   TX clock; the only clock
// - i_reset      in   1   synchronous, active-high reset
// - i_init_done  in   1   transceiver init complete; gearbox idles while low
// - i_txd        in   32  payload half-word; even seq = block bits [31:0], odd seq = [63:32]
// - i_tx_header  in   2   sync header; sampled only on even seq
// - o_tx_pause   out  1   1 = upstream must hold; input this cycle is ignored
// - o_txd        out  32  packed word to the transceiver, bit 0 transmitted first
//
// BEHAVIOUR
// - State
//   - seq: 6-bit counter, 0..SEQ_MAX.
//   - buf: 64-bit leftover register.
//   - fill: bit count held in buf, 0..32.
// - Reset, or i_init_done = 0
//   - Next cycle: seq = 0, buf = 0, fill = 0, o_txd = 0.
//   - o_tx_pause = 1 (combinational).
// - o_tx_pause = i_reset | ~i_init_done | (seq == SEQ_MAX). Combinational, so upstream
//   sees it in the same cycle.
// - Append word
//   - Even seq < SEQ_MAX: {i_txd, i_tx_header}, 34 bits.
//   - Odd seq: i_txd, 32 bits.
//   - seq == SEQ_MAX: nothing; input is ignored.
// - Each cycle: cat = (append << fill) | buf. Then o_txd <= cat[31:0],
//   buf <= cat >> 32, fill <= fill + len(append) - 32.
// - Fill sequence (required; checked by assertion)
//   - Fill before even seq 2k is 2k; before odd seq 2k+1 it is 2k+2.
//   - Fill at seq == SEQ_MAX is 32. That cycle outputs buf[31:0] and fill becomes 0.
// - seq wraps SEQ_MAX -> 0. It increments every cycle while i_init_done = 1 and i_reset = 0.
// - Latency: 1 cycle, input word to first output bit, registered output.
//   There is no combinational path from i_txd to o_txd.
// - i_init_done falling mid-block: the partial block is discarded and the state reinitialises.
//   On the rise, output restarts aligned at seq 0 with a header first.
// - Reset mid-operation: same discard. Reset has priority over i_init_done.
//
// CONFIGURATION
// - GEARBOX_DEBUG_EN defined: adds ports o_dbg_seq (6, out) = seq and o_dbg_fill (6, out) = fill,
//   plus SVA asserting the fill sequence above and fill <= 32.
// - GEARBOX_DEBUG_EN undefined: those ports and assertions are absent.
//   Datapath behaviour is identical in both cases.
//
// STRUCTURE
// - code_defs_pkg: add GEARBOX_SEQ_MAX = 32 and GEARBOX_PERIOD = 33.
//   Reuse the existing SYNC_DATA and SYNC_CTL constants in the bench.
// - A sub-module gearbox_seq_ctr is natural. It owns the 0..SEQ_MAX counter and the pause
//   decode, and is shared with a future RX gearbox.
// - The packing datapath stays in this module.
//
// TESTING
// - Reset sequence: reset 1 -> 0 with init_done = 1 -> o_txd = 0 one cycle after reset,
//   o_tx_pause = 0 while seq = 0 is active, o_tx_pause = 1 at exactly seq 32.
// - Single block: header 2'b01, low = 32'hFFFF_FFFF, high = 32'h0000_0000
//   -> o_txd words 32'hFFFF_FFFD, then 32'h0000_0003.
// - 16-block idle stream: header 2'b10, payload 64'h1E
//   -> deserialising 33 o_txd words yields 16 identical 66-bit blocks.
//   Pause is high on cycles 32, 65, 98 (33-cycle period).
// - Pause honoured: drive garbage on i_txd/i_tx_header while o_tx_pause = 1
//   -> output bitstream unchanged against the golden model.
// - init_done drop at seq 17, held low 5 cycles -> o_txd = 0 and pause = 1 throughout.
//   After the rise, the first word carries a header in bits [1:0].
// - Random long run: 10k random blocks through a 66-bit reference unpacker
//   -> zero mismatches; the fill assertion never fires with GEARBOX_DEBUG_EN.

Source files
------------

// File: rtl/code_defs_pkg.sv
// Shared 64b/66b code constants and gearbox timing constants.
package code_defs_pkg;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTL  = 2'b10;

  localparam int GEARBOX_SEQ_MAX = 32;
  localparam int GEARBOX_PERIOD  = GEARBOX_SEQ_MAX + 1;
endpackage

// File: rtl/tx_gearbox_66_32_if.sv
// Upstream block stream plus the packed word heading to the transceiver.
interface tx_gearbox_66_32_if;
  logic        init_done;
  logic [31:0] txd;
  logic [1:0]  tx_header;
  logic        tx_pause;
  logic [31:0] tx_word;

  modport master (output init_done, txd, tx_header, input tx_pause, tx_word);
  modport slave  (input init_done, txd, tx_header, output tx_pause, tx_word);
endinterface

// File: rtl/tx_gearbox_66_32_seq_ctr.sv
// 0..SEQ_MAX sequence counter with pause decode; shared between TX and RX gearboxes.
module gearbox_seq_ctr #(
  parameter int SEQ_MAX = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [5:0] seq_o,
  output logic       pause_o
);
  localparam logic [5:0] SEQ_LAST = 6'(SEQ_MAX);

  logic [5:0] seq_q, seq_d;

  always_comb begin
    seq_d = seq_q + 6'd1;
    if (!en_i || seq_q == SEQ_LAST) seq_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) seq_q <= '0;
    else       seq_q <= seq_d;
  end

  assign seq_o   = seq_q;
  assign pause_o = rst_i | ~en_i | (seq_q == SEQ_LAST);
endmodule

// File: rtl/tx_gearbox_66_32.sv
// 66b -> 32b TX gearbox: packs header+payload LSB-first, pausing upstream once per period.
// Define GEARBOX_DEBUG_EN for seq/fill debug ports and fill-sequence assertions.
module tx_gearbox_66_32
  import code_defs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEQ_MAX    = GEARBOX_SEQ_MAX
) (
  input  logic                i_txc,
  input  logic                i_reset,
  tx_gearbox_66_32_if.slave   gb
`ifdef GEARBOX_DEBUG_EN
  ,
  output logic [5:0]          o_dbg_seq,
  output logic [5:0]          o_dbg_fill
`endif
);
  localparam logic [5:0] SEQ_LAST = 6'(SEQ_MAX);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("tx_gearbox_66_32: only DATA_WIDTH = 32 is supported");
  end

  logic [5:0]  seq;
  logic        pause;
  logic        accept;
  logic [63:0] buf_q, buf_d;
  logic [5:0]  fill_q, fill_d;
  logic [31:0] txd_q, txd_d;
  logic [33:0] app;
  logic [5:0]  app_len;
  logic [65:0] cat;

  gearbox_seq_ctr #(.SEQ_MAX(SEQ_MAX)) u_seq (
    .clk_i  (i_txc),
    .rst_i  (i_reset),
    .en_i   (gb.init_done),
    .seq_o  (seq),
    .pause_o(pause)
  );

  assign accept = ~i_reset & gb.init_done & (seq != SEQ_LAST);

  // Even slots carry the header in front of the low half; at SEQ_LAST only the leftover drains.
  always_comb begin
    app     = '0;
    app_len = 6'd0;
    if (accept) begin
      if (!seq[0]) begin
        app     = {gb.txd, gb.tx_header};
        app_len = 6'd34;
      end else begin
        app     = {2'b00, gb.txd};
        app_len = 6'd32;
      end
    end
    cat    = ({32'b0, app} << fill_q) | {2'b00, buf_q};
    txd_d  = cat[31:0];
    buf_d  = {30'b0, cat[65:32]};
    fill_d = fill_q + app_len - 6'd32;
  end

  always_ff @(posedge i_txc) begin
    if (i_reset || !gb.init_done) begin
      buf_q  <= '0;
      fill_q <= '0;
      txd_q  <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      txd_q  <= txd_d;
    end
  end

  assign gb.tx_word  = txd_q;
  assign gb.tx_pause = pause;

`ifdef GEARBOX_DEBUG_EN
  assign o_dbg_seq  = seq;
  assign o_dbg_fill = fill_q;

  a_fill_max: assert property (@(posedge i_txc) disable iff (i_reset) fill_q <= 6'd32);
  a_fill_seq: assert property (@(posedge i_txc) disable iff (i_reset)
    (seq == SEQ_LAST) ? (fill_q == 6'd32) :
    (seq[0] ? (fill_q == seq + 6'd1) : (fill_q == seq)));
`endif
endmodule
